// File: rtl/issue_scheduler_pkg.sv
// Shared unit codes, CDB slot payload and counter widths for the issue scheduler.
package issue_scheduler_pkg;

  localparam int unsigned W_UNIT  = 2;
  localparam int unsigned N_UNITS = 4;
  localparam int unsigned W_LAT   = 4;

  typedef logic [W_UNIT-1:0] unit_t;

  localparam unit_t UNIT_INT  = 2'd0;
  localparam unit_t UNIT_LS   = 2'd1;
  localparam unit_t UNIT_MULT = 2'd2;
  localparam unit_t UNIT_DIV  = 2'd3;

  typedef struct packed {
    logic  valid;
    unit_t unit;
  } slot_t;

endpackage

// File: rtl/issue_scheduler_cdb_slot_table.sv
// CDB reservation calendar: slot k describes the CDB publisher k cycles from now.
// Shifts toward slot 0 every cycle; one reservation write per cycle.
module issue_scheduler_cdb_slot_table
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned IDX_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rsv_valid_i,
  input  logic [IDX_W-1:0] rsv_idx_i,
  input  unit_t            rsv_unit_i,
  output logic [DEPTH:0]   busy_o,
  output slot_t            head_o
);

  slot_t [DEPTH:0] slot_q, slot_d;

  // Shift one cycle closer, then drop the new reservation into the post-shift slot.
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot_d[k] = slot_q[k+1];
    end
    if (rsv_valid_i) begin
      slot_d[rsv_idx_i] = '{valid: 1'b1, unit: rsv_unit_i};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    for (int k = 0; k <= int'(DEPTH); k++) begin
      busy_o[k] = slot_q[k].valid;
    end
  end

  assign head_o = slot_q[0];

endmodule

// File: rtl/issue_scheduler.sv
// Single-issue arbiter for INT/LS/MULT/DIV with CDB collision avoidance.
// Define ISSUE_RR_EN for round-robin arbitration; default is fixed DIV > MULT > LS > INT.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int unsigned INT_LAT  = 1,
  parameter int unsigned LS_LAT   = 2,
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 7
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  int_req,
  input  logic  ls_req,
  input  logic  mult_req,
  input  logic  div_req,
  input  logic  flush,
  output logic  int_grant,
  output logic  ls_grant,
  output logic  mult_grant,
  output logic  div_grant,
  output logic  div_busy,
  output unit_t cdb_sel,
  output logic  cdb_sel_valid
);

  localparam int unsigned IDX_W = $clog2(DIV_LAT + 1);

  if (INT_LAT < 1 || INT_LAT > 15 || LS_LAT < 1 || LS_LAT > 15 ||
      MULT_LAT < 1 || MULT_LAT > 15 || DIV_LAT < 1 || DIV_LAT > 15 ||
      DIV_LAT < INT_LAT || DIV_LAT < LS_LAT || DIV_LAT < MULT_LAT) begin : g_bad_lat
    $error("issue_scheduler: latency parameters out of range");
  end

  logic [DIV_LAT:0]   busy;
  slot_t              head;
  logic [N_UNITS-1:0] elig_c, gnt_c;
  unit_t              gnt_unit;
  logic [IDX_W-1:0]   rsv_idx;
  logic [W_LAT-1:0]   div_cnt_q, div_cnt_d;
  logic               busy_unused;

  // A unit may issue only if its publish cycle is still free on the CDB.
  always_comb begin
    elig_c = '0;
    if (reset && !flush) begin
      elig_c[UNIT_INT]  = int_req  && !busy[INT_LAT];
      elig_c[UNIT_LS]   = ls_req   && !busy[LS_LAT];
      elig_c[UNIT_MULT] = mult_req && !busy[MULT_LAT];
      elig_c[UNIT_DIV]  = div_req  && !busy[DIV_LAT] && (div_cnt_q == '0);
    end
  end

`ifdef ISSUE_RR_EN
  unit_t rr_ptr_q, rr_ptr_d;
  unit_t cand;
  logic  found;

  always_comb begin
    gnt_c    = '0;
    gnt_unit = UNIT_INT;
    found    = 1'b0;
    cand     = rr_ptr_q;
    for (int i = 0; i < int'(N_UNITS); i++) begin
      cand = rr_ptr_q + W_UNIT'(i);
      if (!found && elig_c[cand]) begin
        gnt_c[cand] = 1'b1;
        gnt_unit    = cand;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt_c) rr_ptr_d = gnt_unit + W_UNIT'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) rr_ptr_q <= UNIT_INT;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    gnt_c    = '0;
    gnt_unit = UNIT_INT;
    if (elig_c[UNIT_DIV]) begin
      gnt_c[UNIT_DIV] = 1'b1;
      gnt_unit        = UNIT_DIV;
    end else if (elig_c[UNIT_MULT]) begin
      gnt_c[UNIT_MULT] = 1'b1;
      gnt_unit         = UNIT_MULT;
    end else if (elig_c[UNIT_LS]) begin
      gnt_c[UNIT_LS] = 1'b1;
      gnt_unit       = UNIT_LS;
    end else if (elig_c[UNIT_INT]) begin
      gnt_c[UNIT_INT] = 1'b1;
      gnt_unit        = UNIT_INT;
    end
  end
`endif

  // Reservation lands one below the latency because the table shifts on the same edge.
  always_comb begin
    rsv_idx = IDX_W'(INT_LAT - 1);
    case (gnt_unit)
      UNIT_LS:   rsv_idx = IDX_W'(LS_LAT - 1);
      UNIT_MULT: rsv_idx = IDX_W'(MULT_LAT - 1);
      UNIT_DIV:  rsv_idx = IDX_W'(DIV_LAT - 1);
      default:   ;
    endcase
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (gnt_c[UNIT_DIV])        div_cnt_d = W_LAT'(DIV_LAT - 1);
    else if (div_cnt_q != '0)   div_cnt_d = div_cnt_q - W_LAT'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) div_cnt_q <= '0;
    else        div_cnt_q <= div_cnt_d;
  end

  issue_scheduler_cdb_slot_table #(
    .DEPTH (DIV_LAT),
    .IDX_W (IDX_W)
  ) u_slot_table (
    .clk         (clk),
    .reset       (reset),
    .rsv_valid_i (|gnt_c),
    .rsv_idx_i   (rsv_idx),
    .rsv_unit_i  (gnt_unit),
    .busy_o      (busy),
    .head_o      (head)
  );

  assign busy_unused   = ^busy;
  assign int_grant     = gnt_c[UNIT_INT];
  assign ls_grant      = gnt_c[UNIT_LS];
  assign mult_grant    = gnt_c[UNIT_MULT];
  assign div_grant     = gnt_c[UNIT_DIV];
  assign div_busy      = (div_cnt_q != '0);
  assign cdb_sel       = head.unit;
  assign cdb_sel_valid = head.valid;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios then random traffic against a CDB-calendar model.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic  clk = 1'b0;
  logic  reset, int_req, ls_req, mult_req, div_req, flush;
  logic  int_grant, ls_grant, mult_grant, div_grant, div_busy, cdb_sel_valid;
  unit_t cdb_sel;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int own [64];      // CDB owner per absolute cycle (mod 64), -1 when free
  int div_next = 0;  // first cycle the divider may accept again
  int rr = 0;
  bit prev_rst = 1'b0;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .int_req       (int_req),
    .ls_req        (ls_req),
    .mult_req      (mult_req),
    .div_req       (div_req),
    .flush         (flush),
    .int_grant     (int_grant),
    .ls_grant      (ls_grant),
    .mult_grant    (mult_grant),
    .div_grant     (div_grant),
    .div_busy      (div_busy),
    .cdb_sel       (cdb_sel),
    .cdb_sel_valid (cdb_sel_valid)
  );

  function automatic int lat_of(input int u);
    case (u)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive, compare against model, advance model. xg: -2 no directed
  // expectation, -1 expect no grant, else expected granted unit.
  task automatic run_cycle(input bit r, input bit [3:0] req, input bit f, input int xg);
    bit         el [4];
    int         g;
    logic [3:0] exp_g, dut_g;
    reset = r; int_req = req[0]; ls_req = req[1]; mult_req = req[2]; div_req = req[3]; flush = f;
    #4;
    check("cdb_sel_valid", cdb_sel_valid, own[cyc % 64] != -1);
    if (own[cyc % 64] != -1) check("cdb_sel", cdb_sel, own[cyc % 64]);
    if (prev_rst) check("cdb_sel_after_reset", cdb_sel, UNIT_INT);
    check("div_busy", div_busy, div_next > cyc);
    for (int u = 0; u < 4; u++)
      el[u] = r && req[u] && !f && (own[(cyc + lat_of(u)) % 64] == -1) && (u != 3 || div_next <= cyc);
    g = -1;
`ifdef ISSUE_RR_EN
    for (int i = 0; i < 4; i++) if (g < 0 && el[(rr + i) % 4]) g = (rr + i) % 4;
`else
    for (int u = 3; u >= 0; u--) if (g < 0 && el[u]) g = u;
`endif
    exp_g = '0;
    if (g >= 0) exp_g[g] = 1'b1;
    dut_g = {div_grant, mult_grant, ls_grant, int_grant};
    check("grants", dut_g, exp_g);
    if (xg != -2) begin
      exp_g = '0;
      if (xg >= 0) exp_g[xg] = 1'b1;
      check("directed_grant", dut_g, exp_g);
    end
    own[cyc % 64] = -1;
    if (!r) begin
      for (int i = 0; i < 64; i++) own[i] = -1;
      div_next = 0;
      rr = 0;
    end else if (g >= 0) begin
      own[(cyc + lat_of(g)) % 64] = g;
      if (g == 3) div_next = cyc + 7;
      rr = (g + 1) % 4;
    end
    prev_rst = !r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic settle();
    run_cycle(1'b0, 4'b0000, 1'b0, -1);
    repeat (3) run_cycle(1'b1, 4'b0000, 1'b0, -1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) own[i] = -1;
    reset = 1'b0; int_req = 1'b0; ls_req = 1'b0; mult_req = 1'b0; div_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then INT alone publishes the next cycle.
    settle();
    run_cycle(1'b1, 4'b0001, 1'b0, 0);
    run_cycle(1'b1, 4'b0000, 1'b0, -1);

    // MULT reservation blocks INT exactly three cycles later.
    settle();
    run_cycle(1'b1, 4'b0100, 1'b0, 2);
`ifndef ISSUE_RR_EN
    run_cycle(1'b1, 4'b0001, 1'b0, 0);
    run_cycle(1'b1, 4'b0001, 1'b0, 0);
    run_cycle(1'b1, 4'b0001, 1'b0, -1);
    run_cycle(1'b1, 4'b0001, 1'b0, 0);
`else
    repeat (4) run_cycle(1'b1, 4'b0001, 1'b0, -2);
`endif

    // Divider held: grants every seventh cycle.
    settle();
    for (int i = 0; i < 15; i++) run_cycle(1'b1, 4'b1000, 1'b0, (i % 7 == 0) ? 3 : -1);
    repeat (8) run_cycle(1'b1, 4'b0000, 1'b0, -2);

    // All four held.
    settle();
`ifndef ISSUE_RR_EN
    run_cycle(1'b1, 4'b1111, 1'b0, 3);
    run_cycle(1'b1, 4'b1111, 1'b0, 2);
`else
    run_cycle(1'b1, 4'b1111, 1'b0, 0);
    run_cycle(1'b1, 4'b1111, 1'b0, 1);
`endif
    repeat (12) run_cycle(1'b1, 4'b1111, 1'b0, -2);

    // INT and LS held from reset.
    settle();
`ifdef ISSUE_RR_EN
    run_cycle(1'b1, 4'b0011, 1'b0, 0);
    run_cycle(1'b1, 4'b0011, 1'b0, 1);
`else
    run_cycle(1'b1, 4'b0011, 1'b0, 1);
    run_cycle(1'b1, 4'b0011, 1'b0, 1);
`endif
    repeat (8) run_cycle(1'b1, 4'b0011, 1'b0, -2);

    // Flush blocks a grant but the earlier reservation still publishes.
    settle();
    run_cycle(1'b1, 4'b0100, 1'b0, 2);
    run_cycle(1'b1, 4'b0100, 1'b1, -1);
    run_cycle(1'b1, 4'b0000, 1'b0, -1);
    repeat (3) run_cycle(1'b1, 4'b0000, 1'b0, -1);

    // Reset mid-stream drops in-flight reservations and the divider count.
    run_cycle(1'b1, 4'b1000, 1'b0, 3);
    run_cycle(1'b1, 4'b0001, 1'b0, 0);
    run_cycle(1'b0, 4'b1111, 1'b0, -1);
    run_cycle(1'b1, 4'b0000, 1'b0, -1);
    repeat (8) run_cycle(1'b1, 4'b0000, 1'b0, -1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++)
      run_cycle($urandom_range(0, 39) != 0, 4'($urandom), $urandom_range(0, 7) == 0, -2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
